// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_stall_ctrl
//  Purpose  : Stall/flush controller for the 5-stage RV32I pipeline: reset
//             fetch hold, load-use bubbles, branch flushes, memory freeze.
//  Options  : PIPE_PERF_CNT_EN adds stall/flush/load-use event counters.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl #(
   parameter int RESET_HOLD_CYCLES = 2,
   parameter int MEM_TIMEOUT       = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  D_rs1,
   input  logic [4:0]  D_rs2,
   input  logic [6:0]  D_opcode,
   input  logic [6:0]  E_opcode,
   input  logic [4:0]  E_rd,
   input  logic        E_reg_write,
   input  logic        E_pc_src,
   input  logic        mem_busy,
   input  logic        timeout_clr,
   output logic        stall_F,
   output logic        stall_D,
   output logic        stall_E,
   output logic        stall_M,
   output logic        stall_W,
   output logic        flush_D,
   output logic        flush_E,
   output logic        redirect_en,
   output logic        mem_timeout
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_flush_events,
   output logic [31:0] perf_load_use
`endif
);

   localparam logic [1:0] c_ST_HOLD     = 2'd0;
   localparam logic [1:0] c_ST_RUN      = 2'd1;
   localparam logic [1:0] c_ST_MEM_WAIT = 2'd2;

   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_LUI    = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;
   localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

   localparam logic [3:0] c_HOLD_LAST = 4'(RESET_HOLD_CYCLES - 1);
   localparam logic [9:0] c_BUSY_MAX  = 10'(MEM_TIMEOUT);

   logic [1:0] r_state;
   logic [3:0] r_hold_cnt;
   logic [9:0] r_busy_cnt;
   logic       r_mem_timeout;

   logic [1:0] w_state_nxt;
   logic [3:0] w_hold_cnt_nxt;
   logic [9:0] w_busy_cnt_nxt;
   logic       w_timeout_set;
   logic       w_rs1_used;
   logic       w_rs2_used;
   logic       w_load_use;

   assign w_rs1_used = (D_opcode != c_OP_LUI) && (D_opcode != c_OP_AUIPC) &&
                       (D_opcode != c_OP_JAL);
   assign w_rs2_used = (D_opcode == c_OP_RTYPE) || (D_opcode == c_OP_STORE) ||
                       (D_opcode == c_OP_BRANCH);
   assign w_load_use = (E_opcode == c_OP_LOAD) && E_reg_write && (E_rd != 5'd0) &&
                       ((w_rs1_used && (D_rs1 == E_rd)) ||
                        (w_rs2_used && (D_rs2 == E_rd)));

   // Saturation keeps the set condition true, so a same-cycle clear loses.
   assign w_timeout_set = (r_state != c_ST_HOLD) && mem_busy &&
                          (w_busy_cnt_nxt == c_BUSY_MAX);
   assign mem_timeout   = r_mem_timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= c_ST_HOLD;
         r_hold_cnt    <= 4'd0;
         r_busy_cnt    <= 10'd0;
         r_mem_timeout <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_hold_cnt <= w_hold_cnt_nxt;
         r_busy_cnt <= w_busy_cnt_nxt;
         if (w_timeout_set)
            r_mem_timeout <= 1'b1;
         else if (timeout_clr)
            r_mem_timeout <= 1'b0;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_hold_cnt_nxt = r_hold_cnt;
      w_busy_cnt_nxt = r_busy_cnt;
      case (r_state)
         c_ST_HOLD: begin
            if (r_hold_cnt == c_HOLD_LAST) begin
               w_state_nxt    = c_ST_RUN;
               w_hold_cnt_nxt = 4'd0;
            end else begin
               w_hold_cnt_nxt = r_hold_cnt + 4'd1;
            end
         end
         c_ST_RUN: begin
            if (mem_busy) begin
               w_state_nxt    = c_ST_MEM_WAIT;
               w_busy_cnt_nxt = 10'd1;
            end
         end
         c_ST_MEM_WAIT: begin
            if (mem_busy) begin
               if (r_busy_cnt != c_BUSY_MAX)
                  w_busy_cnt_nxt = r_busy_cnt + 10'd1;
            end else begin
               w_state_nxt    = c_ST_RUN;
               w_busy_cnt_nxt = 10'd0;
            end
         end
         default: begin
            w_state_nxt    = c_ST_HOLD;
            w_hold_cnt_nxt = 4'd0;
            w_busy_cnt_nxt = 10'd0;
         end
      endcase
   end

   // Release from MEM_WAIT shares the RUN decode, so a branch held in EX
   // during the freeze redirects exactly once.
   always_comb begin
      stall_F     = 1'b0;
      stall_D     = 1'b0;
      stall_E     = 1'b0;
      stall_M     = 1'b0;
      stall_W     = 1'b0;
      flush_D     = 1'b0;
      flush_E     = 1'b0;
      redirect_en = 1'b0;
      case (r_state)
         c_ST_RUN, c_ST_MEM_WAIT: begin
            if (mem_busy) begin
               stall_F = 1'b1;
               stall_D = 1'b1;
               stall_E = 1'b1;
               stall_M = 1'b1;
               stall_W = 1'b1;
            end else if (E_pc_src) begin
               flush_D     = 1'b1;
               flush_E     = 1'b1;
               redirect_en = 1'b1;
            end else if (w_load_use) begin
               stall_F = 1'b1;
               stall_D = 1'b1;
               flush_E = 1'b1;
            end
         end
         default: begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_D = 1'b1;
            flush_E = 1'b1;
         end
      endcase
   end

`ifdef PIPE_PERF_CNT_EN
   logic r_unused_perf;
   logic w_rule_load_use;
   logic w_any_stall;

   assign w_rule_load_use = ((r_state == c_ST_RUN) || (r_state == c_ST_MEM_WAIT)) &&
                            !mem_busy && !E_pc_src && w_load_use;
   assign w_any_stall     = stall_F | stall_D | stall_E | stall_M | stall_W;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cycles <= 32'd0;
         perf_flush_events <= 32'd0;
         perf_load_use     <= 32'd0;
         r_unused_perf     <= 1'b0;
      end else begin
         if ((r_state != c_ST_HOLD) && w_any_stall)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (redirect_en)
            perf_flush_events <= perf_flush_events + 32'd1;
         if (w_rule_load_use)
            perf_load_use <= perf_load_use + 32'd1;
         r_unused_perf <= 1'b0;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_stall_ctrl
//  Purpose  : Self-checking bench: vector table, corner sequences, random run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

   localparam int HOLD_N = 2;
   localparam int TMO_N  = 4;

   localparam logic [6:0] OP_LOAD = 7'b0000011, OP_LUI = 7'b0110111,
                          OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                          OP_R = 7'b0110011, OP_STORE = 7'b0100011,
                          OP_BR = 7'b1100011, OP_IMM = 7'b0010011,
                          OP_JALR = 7'b1100111;

   // {stall_F, stall_D, stall_E, stall_M, stall_W, flush_D, flush_E, redirect_en}
   localparam logic [7:0] EXP_HOLD = 8'b11000110;
   localparam logic [7:0] EXP_BUSY = 8'b11111000;
   localparam logic [7:0] EXP_BR   = 8'b00000111;
   localparam logic [7:0] EXP_LU   = 8'b11000010;
   localparam logic [7:0] EXP_NONE = 8'b00000000;

   logic       clk;
   logic       rst_n;
   logic [4:0] D_rs1, D_rs2, E_rd;
   logic [6:0] D_opcode, E_opcode;
   logic       E_reg_write, E_pc_src, mem_busy, timeout_clr;
   logic       stall_F, stall_D, stall_E, stall_M, stall_W;
   logic       flush_D, flush_E, redirect_en, mem_timeout;
   logic [7:0] dut_outs;

   int checks   = 0;
   int failures = 0;

   pipeline_stall_ctrl #(
      .RESET_HOLD_CYCLES(HOLD_N),
      .MEM_TIMEOUT      (TMO_N)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .D_rs1      (D_rs1),
      .D_rs2      (D_rs2),
      .D_opcode   (D_opcode),
      .E_opcode   (E_opcode),
      .E_rd       (E_rd),
      .E_reg_write(E_reg_write),
      .E_pc_src   (E_pc_src),
      .mem_busy   (mem_busy),
      .timeout_clr(timeout_clr),
      .stall_F    (stall_F),
      .stall_D    (stall_D),
      .stall_E    (stall_E),
      .stall_M    (stall_M),
      .stall_W    (stall_W),
      .flush_D    (flush_D),
      .flush_E    (flush_E),
      .redirect_en(redirect_en),
      .mem_timeout(mem_timeout)
   );

   assign dut_outs = {stall_F, stall_D, stall_E, stall_M, stall_W,
                      flush_D, flush_E, redirect_en};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [6:0] dop;
      logic [6:0] eop;
      logic [4:0] erd;
      logic       ewe;
      logic       pc;
      logic       busy;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [7:0] exp, input logic exp_tmo);
      checks++;
      if ({dut_outs, mem_timeout} !== {exp, exp_tmo}) begin
         failures++;
         $display("FAIL %s: got outs=%b tmo=%b, expected outs=%b tmo=%b",
                  name, dut_outs, mem_timeout, exp, exp_tmo);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [6:0] dop, input logic [6:0] eop,
                         input logic [4:0] erd, input logic ewe,
                         input logic pc, input logic busy);
      D_rs1 = rs1; D_rs2 = rs2; D_opcode = dop; E_opcode = eop;
      E_rd = erd; E_reg_write = ewe; E_pc_src = pc; mem_busy = busy;
   endtask

   function automatic bit ref_load_use(input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [6:0] dop, input logic [6:0] eop,
                                       input logic [4:0] erd, input logic ewe);
      bit uses1, uses2;
      uses1 = !(dop inside {OP_LUI, OP_AUIPC, OP_JAL});
      uses2 = dop inside {OP_R, OP_STORE, OP_BR};
      return (eop == OP_LOAD) && ewe && (erd != 5'd0) &&
             ((uses1 && rs1 == erd) || (uses2 && rs2 == erd));
   endfunction

   // Reference model: remaining hold cycles, current busy-run length, sticky flag.
   int         m_hold;
   int         m_busy;
   bit         m_tmo;
   logic [6:0] ops[9];
   int         busy_left;
   logic [7:0] exp_o;

   initial begin
      vecs[0]  = '{5'd5, 5'd7, OP_R,     OP_LOAD, 5'd5, 1'b1, 1'b0, 1'b0, EXP_LU};
      vecs[1]  = '{5'd5, 5'd5, OP_LUI,   OP_LOAD, 5'd5, 1'b1, 1'b0, 1'b0, EXP_NONE};
      vecs[2]  = '{5'd0, 5'd0, OP_R,     OP_LOAD, 5'd0, 1'b1, 1'b0, 1'b0, EXP_NONE};
      vecs[3]  = '{5'd7, 5'd5, OP_R,     OP_LOAD, 5'd5, 1'b1, 1'b0, 1'b0, EXP_LU};
      vecs[4]  = '{5'd1, 5'd5, OP_IMM,   OP_LOAD, 5'd5, 1'b1, 1'b0, 1'b0, EXP_NONE};
      vecs[5]  = '{5'd2, 5'd9, OP_STORE, OP_LOAD, 5'd9, 1'b1, 1'b0, 1'b0, EXP_LU};
      vecs[6]  = '{5'd3, 5'd9, OP_BR,    OP_LOAD, 5'd9, 1'b1, 1'b0, 1'b0, EXP_LU};
      vecs[7]  = '{5'd5, 5'd5, OP_JAL,   OP_LOAD, 5'd5, 1'b1, 1'b0, 1'b0, EXP_NONE};
      vecs[8]  = '{5'd5, 5'd5, OP_AUIPC, OP_LOAD, 5'd5, 1'b1, 1'b0, 1'b0, EXP_NONE};
      vecs[9]  = '{5'd5, 5'd1, OP_JALR,  OP_LOAD, 5'd5, 1'b1, 1'b0, 1'b0, EXP_LU};
      vecs[10] = '{5'd5, 5'd7, OP_R,     OP_LOAD, 5'd5, 1'b0, 1'b0, 1'b0, EXP_NONE};
      vecs[11] = '{5'd5, 5'd7, OP_R,     OP_R,    5'd5, 1'b1, 1'b0, 1'b0, EXP_NONE};
      vecs[12] = '{5'd5, 5'd7, OP_R,     OP_LOAD, 5'd5, 1'b1, 1'b1, 1'b0, EXP_BR};
      vecs[13] = '{5'd1, 5'd2, OP_R,     OP_R,    5'd5, 1'b1, 1'b1, 1'b0, EXP_BR};
      vecs[14] = '{5'd5, 5'd7, OP_R,     OP_LOAD, 5'd5, 1'b1, 1'b1, 1'b1, EXP_BUSY};
      vecs[15] = '{5'd5, 5'd7, OP_R,     OP_LOAD, 5'd5, 1'b1, 1'b1, 1'b0, EXP_BR};
      ops = '{OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_R, OP_STORE, OP_BR, OP_IMM, OP_JALR};

      // Reset and post-reset fetch hold
      rst_n = 1'b1; timeout_clr = 1'b0;
      set_in(5'd0, 5'd0, OP_IMM, OP_IMM, 5'd0, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #2 check("reset_async", EXP_HOLD, 1'b0);
      tick();
      rst_n = 1'b1;
      #4 check("hold_cycle1", EXP_HOLD, 1'b0);
      tick();
      #4 check("hold_cycle2", EXP_HOLD, 1'b0);
      tick();
      #4 check("run_after_hold", EXP_NONE, 1'b0);
      tick();

      // Decode table
      foreach (vecs[i]) begin
         set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].dop, vecs[i].eop,
                vecs[i].erd, vecs[i].ewe, vecs[i].pc, vecs[i].busy);
         #4 check($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
         tick();
      end

      // Branch held in EX across a 3-cycle freeze
      set_in(5'd1, 5'd2, OP_R, OP_R, 5'd3, 1'b1, 1'b1, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         #4 check($sformatf("freeze_br%0d", k), EXP_BUSY, 1'b0);
         tick();
      end
      mem_busy = 1'b0;
      #4 check("freeze_release", EXP_BR, 1'b0);
      tick();
      E_pc_src = 1'b0;
      #4 check("freeze_after", EXP_NONE, 1'b0);
      tick();

      // Timeout after 4 consecutive busy cycles, then clear
      mem_busy = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         #4 check($sformatf("tmo_busy%0d", k), EXP_BUSY, k >= 5);
         tick();
      end
      mem_busy = 1'b0;
      #4 check("tmo_sticky", EXP_NONE, 1'b1);
      tick();
      timeout_clr = 1'b1;
      #4 check("tmo_clr_cycle", EXP_NONE, 1'b1);
      tick();
      timeout_clr = 1'b0;
      #4 check("tmo_cleared", EXP_NONE, 1'b0);
      tick();

      // Reset asserted in the middle of a memory freeze
      mem_busy = 1'b1;
      for (int k = 1; k <= 5; k++) tick();
      #4 check("wait_before_rst", EXP_BUSY, 1'b1);
      rst_n = 1'b0;
      #1 check("rst_mid_wait", EXP_HOLD, 1'b0);
      tick();
      rst_n = 1'b1;
      #4 check("rst_hold1_busy", EXP_HOLD, 1'b0);
      tick();
      #4 check("rst_hold2_busy", EXP_HOLD, 1'b0);
      tick();
      #4 check("rst_run_busy", EXP_BUSY, 1'b0);
      tick();
      mem_busy = 1'b0;
      tick();

      // Randomized run against the reference model
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m_hold = HOLD_N; m_busy = 0; m_tmo = 1'b0; busy_left = 0;
      for (int n = 0; n < 3000; n++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         if (busy_left > 0) begin
            mem_busy = 1'b1;
            busy_left--;
         end else if ($urandom_range(0, 5) == 0) begin
            mem_busy = 1'b1;
            busy_left = $urandom_range(0, 6);
         end else begin
            mem_busy = 1'b0;
         end
         D_rs1 = 5'($urandom_range(0, 7));
         D_rs2 = 5'($urandom_range(0, 7));
         D_opcode = ops[$urandom_range(0, 8)];
         E_opcode = ($urandom_range(0, 1) == 0) ? OP_LOAD : ops[$urandom_range(0, 8)];
         E_rd = 5'($urandom_range(0, 7));
         E_reg_write = ($urandom_range(0, 3) != 0);
         E_pc_src = ($urandom_range(0, 4) == 0);
         timeout_clr = ($urandom_range(0, 9) == 0);

         if (!rst_n || m_hold > 0)
            exp_o = EXP_HOLD;
         else if (mem_busy)
            exp_o = EXP_BUSY;
         else if (E_pc_src)
            exp_o = EXP_BR;
         else if (ref_load_use(D_rs1, D_rs2, D_opcode, E_opcode, E_rd, E_reg_write))
            exp_o = EXP_LU;
         else
            exp_o = EXP_NONE;
         #4 check($sformatf("rand%0d", n), exp_o, rst_n ? m_tmo : 1'b0);
         tick();

         if (!rst_n) begin
            m_hold = HOLD_N; m_busy = 0; m_tmo = 1'b0;
         end else if (m_hold > 0) begin
            m_hold--;
         end else if (mem_busy) begin
            m_busy = (m_busy + 1 > TMO_N) ? TMO_N : m_busy + 1;
            if (m_busy >= TMO_N) m_tmo = 1'b1;
            else if (timeout_clr) m_tmo = 1'b0;
         end else begin
            m_busy = 0;
            if (timeout_clr) m_tmo = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
